ps2_keyboard_rx: RTL
====================

Name: ps2_keyboard_rx

Overview:
- Receives the keyboard's PS/2 device-to-host serial stream from the ps2_clk/ps2_data board pins.
- Deglitches and deframes 11-bit frames and folds the E0/F0 prefixes into key events.
- Buffers the events in a small FIFO.
- Sits between the board pins and the keyboard matrix logic inside sys; that logic consumes events via a ready/valid handshake.

Parameters:
- CLK_HZ, 25000000: system clock frequency in Hz.
- FILTER_LEN, 8: consecutive equal samples needed before the filtered PS/2 clock changes state.
- TIMEOUT_US, 2000: maximum gap between falling edges inside a frame, in microseconds.
- FIFO_DEPTH, 4: event FIFO entries; must be a power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ps2clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2dat  in  1  raw PS/2 data pin, asynchronous.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head event this cycle.
- ev_code  out  8  scan code of the head event.
- ev_ext  out  1  head event was prefixed by E0.
- ev_release  out  1  head event was prefixed by F0 (key released).
- frame_err  out  1  one-cycle pulse on parity, stop-bit or timeout error.
- overrun  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, FIFO empty, FSM in IDLE, prefix flags cleared.
  - Filtered clock and synchronizers preset to 1.
- Input conditioning:
  - Two-flop synchronizer on each pin.
  - Filtered clock toggles only after FILTER_LEN consecutive synced samples differ from its current value.
  - A falling edge of the filtered clock gives a one-cycle fall strobe. The synced data is sampled in that same cycle.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions on fall only, except timeout.
  - IDLE: data=0 goes to DATA with bitcnt=0. data=1 stays in IDLE silently (no error).
  - DATA: shift in LSB first. After the 8th bit, go to PARITY.
  - PARITY: parity is odd, so XOR of the 8 data bits and the parity bit must be 1. Record pass/fail, go to STOP.
  - STOP: data=1 with parity pass means the byte is good. Otherwise pulse frame_err and clear the prefix flags. Always return to IDLE.
- Timeout:
  - Counter reloads to CLK_HZ/1000000*TIMEOUT_US on every fall and on entering any non-IDLE state.
  - Reaching 0 while not in IDLE: go to IDLE, pulse frame_err, clear prefix flags.
  - In IDLE the counter is held.
- Byte processing, in the cycle after a good STOP:
  - 0xE0 sets ext_pend. 0xF0 sets rel_pend. Neither is pushed.
  - Any other byte (including 0xAA, 0xFA, 0xE1) pushes {ext_pend, rel_pend, byte}, then clears both flags.
- FIFO:
  - Head is presented combinationally: ev_valid = not empty; ev_code, ev_ext and ev_release are the head entry fields.
  - Pop happens when ev_valid and ev_ready.
  - Push while full is accepted only if a pop occurs in the same cycle. Otherwise the event is dropped, overrun pulses and the prefix flags clear.
  - Pointers wrap modulo FIFO_DEPTH. The count has one extra bit so full and empty are distinguishable.
  - ev_ready while empty has no effect.
- Latency:
  - ev_valid rises 2 cycles after the STOP-bit fall strobe: strobe at N, push at N+1, visible at N+2.
  - From a ps2clk pin edge this is at most FILTER_LEN+5 cycles.
- Simultaneous events:
  - frame_err and overrun never pulse in the same cycle.
  - Timeout in the same cycle as a fall: the fall wins.
- Reset mid-frame: discards the partial frame, pending prefixes and FIFO contents.

Decomposition:
- Shared package/header ps2_defs:
  - FSM state encoding.
  - Constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - Event width (10) and field offsets.
- Sub-module ps2_event_fifo (parameter DEPTH, WIDTH=10): synchronous FIFO with the push/pop/full/empty rules above. Same clk/reset.

Test Plan:
- Send 0x1C with parity=0 and stop=1 (FILTER_LEN=8, 40 µs bit period) -> one event with code=0x1C, ext=0, release=0; ev_valid 2 cycles after the STOP strobe; frame_err stays 0.
- Send E0,F0,0x75 then 0x75 -> two events: {ext=1, rel=1, 0x75} then {ext=0, rel=0, 0x75}.
- Send 0x1C with a wrong parity bit, then a good 0x32 -> frame_err pulses once and no event is pushed for 0x1C; the next event is 0x32 with clean flags.
- Send a start bit plus 3 bits, then hold ps2clk high for 2.1 ms, then a good 0x29 -> frame_err pulses once; the next event is 0x29.
- Hold ev_ready=0 and send 5 codes 0x01..0x05 -> ev_valid=1, FIFO holds 0x01..0x04, one overrun pulse on the 5th. Then ev_ready=1 -> 0x01..0x04 popped in order, one per cycle, then ev_valid=0.
- Inject 2-cycle low glitches on ps2clk while idle, then assert reset mid-frame -> no falls are detected from the glitches; after reset all outputs are 0 and the next good frame decodes correctly.

Source files
------------

// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM encoding, prefix
// byte values and the layout of a buffered key event.
package ps2_defs;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int EV_W        = 10;
  localparam int EV_CODE_LSB = 0;
  localparam int EV_REL_BIT  = 8;
  localparam int EV_EXT_BIT  = 9;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_ev_t;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small synchronous FIFO with a combinational head; a push into a full FIFO
// only lands when a pop frees a slot in the same cycle, else it is dropped.
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign dout_o  = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: pin sync and clock deglitch, 11-bit frame
// decode with timeout, E0/F0 prefix folding and an event FIFO.
module ps2_keyboard_rx
  import ps2_defs::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2dat,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_release,
  output logic       frame_err,
  output logic       overrun
);

  localparam int TO_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int TOW    = $clog2(TO_CYC + 1);
  localparam int FW     = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_s_q, dat_s_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall, dat;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_ok_q, par_ok_d;
  logic [TOW-1:0] to_q, to_d;
  logic          byte_vld_q, byte_vld_d;
  logic          err;

  logic          ext_q, ext_d, rel_q, rel_d;
  logic          push, empty, full, drop;
  logic          frame_err_q, overrun_q;
  ps2_ev_t       ev_in;
  logic [EV_W-1:0] head;

  assign dat = dat_s_q[1];

  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall   = 1'b0;
    if (clk_s_q[1] != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = ~filt_q;
        fall   = filt_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    par_ok_d   = par_ok_q;
    to_d       = to_q;
    byte_vld_d = 1'b0;
    err        = 1'b0;
    if (fall) begin
      to_d = TOW'(TO_CYC);
      case (state_q)
        ST_IDLE: begin
          if (!dat) begin
            state_d  = ST_DATA;
            bitcnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shreg_d  = {dat, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_ok_d = odd_parity_ok(shreg_q, dat);
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          if (dat && par_ok_q) byte_vld_d = 1'b1;
          else                 err        = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (to_q == '0) begin
        state_d = ST_IDLE;
        err     = 1'b1;
      end else begin
        to_d = to_q - TOW'(1);
      end
    end
  end

  // shreg_q is stable in the cycle after STOP, so it doubles as the byte latch.
  always_comb begin
    ext_d = ext_q;
    rel_d = rel_q;
    push  = 1'b0;
    if (err) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (byte_vld_q) begin
      if (shreg_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (shreg_q == PS2_BRK) begin
        rel_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
    end
  end

  assign ev_in = '{ext: ext_q, rel: rel_q, code: shreg_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s_q     <= 2'b11;
      dat_s_q     <= 2'b11;
      filt_q      <= 1'b1;
      fcnt_q      <= '0;
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      par_ok_q    <= 1'b0;
      to_q        <= TOW'(TO_CYC);
      byte_vld_q  <= 1'b0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      clk_s_q     <= {clk_s_q[0], ps2clk};
      dat_s_q     <= {dat_s_q[0], ps2dat};
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      par_ok_q    <= par_ok_d;
      to_q        <= to_d;
      byte_vld_q  <= byte_vld_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      frame_err_q <= err;
      overrun_q   <= drop;
    end
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EV_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .din_i  (ev_in),
    .pop_i  (ev_ready),
    .dout_o (head),
    .empty_o(empty),
    .full_o (full),
    .drop_o (drop)
  );

  assign ev_valid   = !empty;
  assign ev_code    = head[EV_CODE_LSB +: 8];
  assign ev_release = head[EV_REL_BIT];
  assign ev_ext     = head[EV_EXT_BIT];
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
